// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcodes, FSM states
// and the shift-amount width helper.
package alu_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0100;
   localparam logic [3:0] OP_MUL  = 4'b0101;
   localparam logic [3:0] OP_SLT  = 4'b0110;
   localparam logic [3:0] OP_SLTU = 4'b0111;
   localparam logic [3:0] OP_NOR  = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b1001;
   localparam logic [3:0] OP_SLL  = 4'b1010;
   localparam logic [3:0] OP_SRL  = 4'b1011;
   localparam logic [3:0] OP_SRA  = 4'b1100;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t MUL  = 2'd1;
   localparam state_t DIV  = 2'd2;

   function automatic int shamt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/seq_muldiv_unit.sv
// Iterative datapath: shift-add unsigned multiply or restoring unsigned
// divide, one bit per cycle; lo/hi/done expose the final step combinationally.
module seq_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             div_sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] hi_r;
   logic [WIDTH-1:0] lo_r;
   logic [WIDTH-1:0] b_r;
   logic [CNT_W-1:0] cnt;
   logic             busy;
   logic             is_div;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   r_sh;
   logic [WIDTH:0]   diff;
   logic             ge;
   logic             last;

   // hi_r is accumulator/remainder, lo_r is multiplier/dividend->quotient
   always_comb begin
      mul_sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : '0);
      r_sh    = {hi_r, lo_r[WIDTH-1]};
      diff    = r_sh - {1'b0, b_r};
      ge      = ~diff[WIDTH];
      if (is_div) begin
         hi = ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
         lo = {lo_r[WIDTH-2:0], ge};
      end else begin
         hi = mul_sum[WIDTH:1];
         lo = {mul_sum[0], lo_r[WIDTH-1:1]};
      end
   end

   assign last = (cnt == CNT_W'(WIDTH - 1));
   assign done = busy && last;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi_r   <= '0;
         lo_r   <= '0;
         b_r    <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         is_div <= 1'b0;
      end else if (start) begin
         hi_r   <= '0;
         lo_r   <= a;
         b_r    <= b;
         cnt    <= '0;
         busy   <= 1'b1;
         is_div <= div_sel;
      end else if (busy) begin
         hi_r <= hi;
         lo_r <= lo;
         cnt  <= cnt + 1'b1;
         if (last)
            busy <= 1'b0;
      end
   end

endmodule

// File: rtl/pipelined_muldiv_alu.sv
// Execute-stage ALU: registered single-cycle ops plus iterative MUL/DIVU
// behind a valid/ready input handshake and an out_valid pulse.
module pipelined_muldiv_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALUControl,
   output logic             out_valid,
   output logic [WIDTH-1:0] ALUResult,
   output logic [WIDTH-1:0] ResultHi,
   output logic             Zero,
   output logic             Overflow,
   output logic             DivByZero
);

   localparam int SHAMT_W = shamt_width(WIDTH);

   state_t             state;
   logic               accept;
   logic               is_mul;
   logic               is_divu;
   logic               b_zero;
   logic               md_start;
   logic               md_done;
   logic [WIDTH-1:0]   md_lo;
   logic [WIDTH-1:0]   md_hi;

   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   add_r;
   logic [WIDTH-1:0]   sub_r;
   logic [WIDTH-1:0]   sc_res;
   logic               sc_ovf;
   logic               sc_known;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid && in_ready;
   assign is_mul   = (ALUControl == OP_MUL);
   assign is_divu  = (ALUControl == OP_DIVU);
   assign b_zero   = ~|B;
   assign md_start = accept && (is_mul || (is_divu && !b_zero));
   assign shamt    = B[SHAMT_W-1:0];

   seq_muldiv_unit #(
      .WIDTH(WIDTH)
   ) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (md_start),
      .div_sel(is_divu),
      .a      (A),
      .b      (B),
      .done   (md_done),
      .lo     (md_lo),
      .hi     (md_hi)
   );

   always_comb begin
      add_r    = A + B;
      sub_r    = A - B;
      sc_res   = '0;
      sc_ovf   = 1'b0;
      sc_known = 1'b1;
      case (ALUControl)
         OP_AND:  sc_res = A & B;
         OP_OR:   sc_res = A | B;
         OP_XOR:  sc_res = A ^ B;
         OP_NOR:  sc_res = ~(A | B);
         OP_ADD: begin
            sc_res = add_r;
            sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) &&
                     (add_r[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res = sub_r;
            sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) &&
                     (sub_r[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
         OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, A < B};
         OP_SLL:  sc_res = A << shamt;
         OP_SRL:  sc_res = A >> shamt;
         OP_SRA:  sc_res = $signed(A) >>> shamt;
         default: sc_known = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         ALUResult <= '0;
         ResultHi  <= '0;
         Zero      <= 1'b0;
         Overflow  <= 1'b0;
         DivByZero <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_mul) begin
                     state <= MUL;
                  end else if (is_divu && !b_zero) begin
                     state <= DIV;
                  end else if (is_divu) begin
                     out_valid <= 1'b1;
                     ALUResult <= '1;
                     ResultHi  <= A;
                     Zero      <= 1'b0;
                     Overflow  <= 1'b0;
                     DivByZero <= 1'b1;
                  end else begin
                     out_valid <= 1'b1;
                     ALUResult <= sc_res;
                     ResultHi  <= '0;
                     Zero      <= sc_known && ~|sc_res;
                     Overflow  <= sc_ovf;
                     DivByZero <= 1'b0;
                  end
               end
            end
            MUL, DIV: begin
               // final iteration edge: capture the unit's last step directly
               if (md_done) begin
                  state     <= IDLE;
                  out_valid <= 1'b1;
                  ALUResult <= md_lo;
                  ResultHi  <= md_hi;
                  Zero      <= ~|md_lo;
                  Overflow  <= 1'b0;
                  DivByZero <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pipelined_muldiv_alu.sv
// Directed self-checking bench for pipelined_muldiv_alu (WIDTH=32);
// inputs change and outputs are sampled 1ns after each rising edge.
module tb_pipelined_muldiv_alu;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [3:0]   ALUControl;
   logic         out_valid;
   logic [W-1:0] ALUResult;
   logic [W-1:0] ResultHi;
   logic         Zero;
   logic         Overflow;
   logic         DivByZero;

   int checks   = 0;
   int failures = 0;
   int stray;
   int busy_bad;

   pipelined_muldiv_alu #(
      .WIDTH(W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .ALUControl(ALUControl),
      .out_valid (out_valid),
      .ALUResult (ALUResult),
      .ResultHi  (ResultHi),
      .Zero      (Zero),
      .Overflow  (Overflow),
      .DivByZero (DivByZero)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
      ALUControl = op;
      A          = a;
      B          = b;
      in_valid   = 1'b1;
      tick();
      in_valid   = 1'b0;
   endtask

   task automatic chk_res(input string tag, input logic [W-1:0] res,
                          input logic [W-1:0] hi, input logic z,
                          input logic ov, input logic dz);
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_res"}, 64'(ALUResult), 64'(res));
      chk({tag, "_hi"}, 64'(ResultHi), 64'(hi));
      chk({tag, "_flags"}, 64'({Zero, Overflow, DivByZero}),
          64'({z, ov, dz}));
   endtask

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      A          = '0;
      B          = '0;
      ALUControl = 4'b0000;
      tick();
      tick();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);
      chk("rst_res", 64'(ALUResult), 64'd0);
      chk("rst_hi", 64'(ResultHi), 64'd0);
      chk("rst_flags", 64'({Zero, Overflow, DivByZero}), 64'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_novalid", 64'(out_valid), 64'd0);

      issue(4'b0010, 32'd7, 32'd5);
      chk_res("add", 32'd12, 32'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("add_pulse", 64'(out_valid), 64'd0);
      chk("add_hold", 64'(ALUResult), 64'd12);

      issue(4'b0010, 32'h7FFF_FFFF, 32'd1);
      chk_res("add_ovf", 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b0);
      issue(4'b0100, 32'd5, 32'd5);
      chk_res("sub_zero", 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      issue(4'b0100, 32'h8000_0000, 32'd1);
      chk_res("sub_ovf", 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0);
      issue(4'b0110, 32'hFFFF_FFFF, 32'd1);
      chk_res("slt", 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);
      issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
      chk_res("sltu", 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      issue(4'b1100, 32'h8000_0000, 32'd4);
      chk_res("sra", 32'hF800_0000, 32'd0, 1'b0, 1'b0, 1'b0);
      issue(4'b1011, 32'h8000_0000, 32'h0000_0024);
      chk_res("srl", 32'h0800_0000, 32'd0, 1'b0, 1'b0, 1'b0);
      issue(4'b1010, 32'h0000_0003, 32'd31);
      chk_res("sll", 32'h8000_0000, 32'd0, 1'b0, 1'b0, 1'b0);
      issue(4'b1000, 32'h0F0F_0000, 32'h0000_F0F0);
      chk_res("nor", 32'hF0F0_0F0F, 32'd0, 1'b0, 1'b0, 1'b0);

      // three back-to-back accepts, one result pulse per cycle
      ALUControl = 4'b0000;
      A          = 32'hF0F0_00FF;
      B          = 32'h0FF0_0F0F;
      in_valid   = 1'b1;
      tick();
      chk_res("b2b_and", 32'h00F0_000F, 32'd0, 1'b0, 1'b0, 1'b0);
      ALUControl = 4'b0001;
      tick();
      chk_res("b2b_or", 32'hFFF0_0FFF, 32'd0, 1'b0, 1'b0, 1'b0);
      ALUControl = 4'b0011;
      tick();
      chk_res("b2b_xor", 32'hFF00_0FF0, 32'd0, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;

      // MUL with in_valid pulses and operand changes while busy
      issue(4'b0101, 32'hFFFF_FFFF, 32'd2);
      busy_bad = 0;
      for (int i = 0; i < W; i++) begin
         if (in_ready !== 1'b0 || out_valid !== 1'b0)
            busy_bad++;
         in_valid   = i[0];
         ALUControl = 4'b0010;
         A          = 32'(i);
         B          = 32'd99;
         tick();
      end
      in_valid = 1'b0;
      chk("mul_busy", 64'(busy_bad), 64'd0);
      chk_res("mul", 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0, 1'b0);
      chk("mul_ready", 64'(in_ready), 64'd1);

      // new MUL accepted in the completion cycle
      issue(4'b0101, 32'h1234_5678, 32'h10);
      chk("mul2_busy", 64'({in_ready, out_valid}), 64'd0);
      repeat (W) tick();
      chk_res("mul2", 32'h2345_6780, 32'd1, 1'b0, 1'b0, 1'b0);
      tick();
      chk("mul2_pulse", 64'(out_valid), 64'd0);
      chk("mul2_hold", 64'(ResultHi), 64'd1);

      issue(4'b1001, 32'd100, 32'd7);
      repeat (W) tick();
      chk_res("divu", 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);
      issue(4'b1001, 32'hFFFF_FFFF, 32'h10);
      repeat (W) tick();
      chk_res("divu_max", 32'h0FFF_FFFF, 32'hF, 1'b0, 1'b0, 1'b0);
      issue(4'b1001, 32'd3, 32'd9);
      repeat (W) tick();
      chk_res("divu_small", 32'd0, 32'd3, 1'b1, 1'b0, 1'b0);
      issue(4'b1001, 32'd5, 32'd0);
      chk_res("div0", 32'hFFFF_FFFF, 32'd5, 1'b0, 1'b0, 1'b1);
      issue(4'b1111, 32'd5, 32'd3);
      chk_res("undef", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

      // reset in the middle of a multiply aborts it
      issue(4'b0010, 32'd40, 32'd2);
      issue(4'b0101, 32'd3, 32'd4);
      repeat (9) tick();
      chk("abort_busy", 64'(in_ready), 64'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_valid", 64'(out_valid), 64'd0);
      chk("abort_ready", 64'(in_ready), 64'd1);
      chk("abort_res", 64'(ALUResult), 64'd0);
      chk("abort_hi", 64'(ResultHi), 64'd0);
      chk("abort_flags", 64'({Zero, Overflow, DivByZero}), 64'd0);
      stray = 0;
      for (int i = 0; i < W + 8; i++) begin
         tick();
         if (out_valid !== 1'b0)
            stray++;
      end
      chk("abort_stray", 64'(stray), 64'd0);
      issue(4'b0010, 32'd1, 32'd1);
      chk_res("post_add", 32'd2, 32'd0, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
